ssd_mux_driver: RTL and testbench

//  Time-multiplexed driver for the two-digit PmodSSD. Accepts an 8-bit value over valid/ready,

---
 rtl/ssd_mux_driver_pkg.sv | 31 +++
 rtl/ssd_hex_decoder.sv | 38 +++
 rtl/ssd_mux_driver.sv | 123 ++++++++++++
 tb/tb_ssd_mux_driver.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_mux_driver_pkg.sv
// ---------------------------------------------------------------------------
// ssd_mux_driver_pkg
// Shared definitions for the two-digit seven-segment driver:
//   SEG_0..SEG_F  active-high segment patterns, bit 0 = a ... bit 6 = g
//   SEG_OFF       all segments dark
//   SEL_LSB/MSB   encoding of the digit-select output
// ---------------------------------------------------------------------------
package ssd_mux_driver_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic SEL_LSB = 1'b0;
    localparam logic SEL_MSB = 1'b1;

endpackage

// File: rtl/ssd_hex_decoder.sv
// ---------------------------------------------------------------------------
// ssd_hex_decoder
// Purely combinational hex nibble to seven-segment decoder (active high).
// Ports:
//   nibble  in  4  hex value 0..F
//   seg     out 7  segment pattern, [0]=a ... [6]=g
// ---------------------------------------------------------------------------
module ssd_hex_decoder
    import ssd_mux_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_mux_driver.sv
// ---------------------------------------------------------------------------
// ssd_mux_driver
// Time-multiplexed driver for a two-digit seven-segment display. An 8-bit
// value arrives over valid/ready into a one-entry pending buffer; it is moved
// into the displayed register only at a frame boundary (end of the MSB
// phase, or any cycle while disabled) so a frame never mixes old and new
// digits. Each digit phase starts with a blank gap to suppress ghosting.
//
// Handshake: a transfer happens on a rising clk edge where value_valid and
// value_ready are both 1. value_ready is simply !pend_full (a register), so
// it never depends combinationally on value_valid. The source holds value_in
// stable from raising value_valid until the transfer.
//
// Ports:
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   enable       in   1  1 = scan digits, 0 = dark with sel held at LSB
//   lz_blank     in   1  1 = blank the MSB digit when its nibble is 0
//   value_in     in   8  [3:0] LSB digit, [7:4] MSB digit
//   value_valid  in   1  value_in is valid
//   value_ready  out  1  driver can accept value_in this cycle
//   sel          out  1  0 = LSB digit, 1 = MSB digit
//   digit        out  7  segments, active high, registered and aligned with sel
// ---------------------------------------------------------------------------
module ssd_mux_driver
    import ssd_mux_driver_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       lz_blank,
    input  logic [7:0] value_in,
    input  logic       value_valid,
    output logic       value_ready,
    output logic       sel,
    output logic [6:0] digit
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sel_next;
    logic [7:0]       disp;
    logic [7:0]       disp_next;
    logic [7:0]       pend;
    logic             pend_full;
    logic             pend_full_next;
    logic             xfer;
    logic             boundary;
    logic             take;
    logic [3:0]       nibble;
    logic [6:0]       seg;
    logic [6:0]       digit_next;

    assign value_ready = ~pend_full;

    always_comb begin
        xfer           = value_valid && value_ready;
        // While disabled every cycle is a frame boundary, so a buffered value
        // still reaches disp and the handshake keeps flowing.
        boundary       = !enable || ((sel == SEL_MSB) && (cnt == CNT_LAST));
        take           = boundary && pend_full;
        disp_next      = take ? pend : disp;
        // xfer implies the buffer is empty, so it can never coincide with take.
        pend_full_next = pend_full;
        if (xfer) begin
            pend_full_next = 1'b1;
        end else if (take) begin
            pend_full_next = 1'b0;
        end

        cnt_next = cnt + CNT_W'(1);
        sel_next = sel;
        if (!enable) begin
            cnt_next = '0;
            sel_next = SEL_LSB;
        end else if (cnt == CNT_LAST) begin
            cnt_next = '0;
            sel_next = ~sel;
        end

        // The digit register is computed from next-state values so the
        // pattern on digit always matches the sel and cnt shown alongside it.
        nibble     = (sel_next == SEL_MSB) ? disp_next[7:4] : disp_next[3:0];
        digit_next = seg;
        if (!enable || (cnt_next < BLANK_LIM) ||
            ((sel_next == SEL_MSB) && lz_blank && (disp_next[7:4] == 4'h0))) begin
            digit_next = SEG_OFF;
        end
    end

    ssd_hex_decoder u_hex_decoder (
        .nibble (nibble),
        .seg    (seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            sel       <= SEL_LSB;
            digit     <= SEG_OFF;
            disp      <= 8'h00;
            pend      <= 8'h00;
            pend_full <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            sel       <= sel_next;
            digit     <= digit_next;
            disp      <= disp_next;
            pend_full <= pend_full_next;
            if (xfer) begin
                pend <= value_in;
            end
        end
    end

endmodule

// File: tb/tb_ssd_mux_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_mux_driver
// Two driver instances share all inputs: one with a 2-cycle blank gap and one
// with no blanking. A frame-position model (position 0..2*DIV-1 within the
// LSB+MSB frame) plus a queue of accepted-but-not-shown values predicts sel,
// digit and value_ready for both instances every cycle.
// ---------------------------------------------------------------------------
module tb_ssd_mux_driver;

    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = 2 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       lz_blank = 1'b0;
    logic [7:0] value_in = 8'h00;
    logic       value_valid = 1'b0;
    logic       value_ready, value_ready_nb;
    logic       sel, sel_nb;
    logic [6:0] digit, digit_nb;

    always #5 clk = ~clk;

    ssd_mux_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .lz_blank(lz_blank),
        .value_in(value_in), .value_valid(value_valid), .value_ready(value_ready),
        .sel(sel), .digit(digit)
    );

    ssd_mux_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(0), .CNT_W(4)) dut_nb (
        .clk(clk), .rst_n(rst_n), .enable(enable), .lz_blank(lz_blank),
        .value_in(value_in), .value_valid(value_valid), .value_ready(value_ready_nb),
        .sel(sel_nb), .digit(digit_nb)
    );

    // reference model state
    int         frame_pos;
    logic [7:0] m_disp;
    logic [7:0] exp_q[$];
    logic [6:0] m_digit;
    logic [6:0] m_digit_nb;
    int         total = 0;
    int         bad = 0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[n];
    endfunction

    function automatic logic [6:0] model_digit(input int fp, input int blank,
                                               input logic [7:0] d, input logic lz);
        int  phase;
        logic msb;
        phase = fp % DIV;
        msb   = (fp >= DIV);
        if (phase < blank) return 7'h00;
        if (msb && lz && (d[7:4] == 4'h0)) return 7'h00;
        return msb ? seg_of(d[7:4]) : seg_of(d[3:0]);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic exp_sel;
        logic exp_rdy;
        exp_sel = (frame_pos >= DIV);
        exp_rdy = (exp_q.size() == 0);
        check("sel", {7'b0, sel}, {7'b0, exp_sel});
        check("digit", {1'b0, digit}, {1'b0, m_digit});
        check("ready", {7'b0, value_ready}, {7'b0, exp_rdy});
        check("sel_nb", {7'b0, sel_nb}, {7'b0, exp_sel});
        check("digit_nb", {1'b0, digit_nb}, {1'b0, m_digit_nb});
        check("ready_nb", {7'b0, value_ready_nb}, {7'b0, exp_rdy});
    endtask

    task automatic model_reset();
        frame_pos  = 0;
        m_disp     = 8'h00;
        exp_q.delete();
        m_digit    = 7'h00;
        m_digit_nb = 7'h00;
        value_valid = 1'b0;
    endtask

    // Called at a negedge with inputs set; advances one clock and checks.
    task automatic cycle();
        logic xfer;
        logic boundary;
        if (rst_n) begin
            xfer     = value_valid && (exp_q.size() == 0);
            boundary = !enable || (frame_pos == FRAME - 1);
            if (boundary && exp_q.size() > 0) m_disp = exp_q.pop_front();
            if (xfer) exp_q.push_back(value_in);
            if (enable) begin
                frame_pos  = (frame_pos + 1) % FRAME;
                m_digit    = model_digit(frame_pos, BLK, m_disp, lz_blank);
                m_digit_nb = model_digit(frame_pos, 0, m_disp, lz_blank);
            end else begin
                frame_pos  = 0;
                m_digit    = 7'h00;
                m_digit_nb = 7'h00;
            end
        end else begin
            xfer = 1'b0;
        end
        @(negedge clk);
        if (xfer) value_valid = 1'b0;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic offer(input logic [7:0] v);
        int budget;
        value_in    = v;
        value_valid = 1'b1;
        budget      = 0;
        while (value_valid && budget < 200) begin
            cycle();
            budget++;
        end
        if (value_valid) begin
            check("offer_timeout", 8'h01, 8'h00);
            value_valid = 1'b0;
        end
    endtask

    // Assert reset between edges and check outputs before any clk edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_sel"}, {7'b0, sel}, 8'h00);
        check({tag, "_digit"}, {1'b0, digit}, 8'h00);
        check({tag, "_ready"}, {7'b0, value_ready}, 8'h01);
        check({tag, "_ready_nb"}, {7'b0, value_ready_nb}, 8'h01);
        @(negedge clk);
        check_outputs();
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int budget;
        model_reset();
        // Power-on reset, checked before the first clk edge.
        async_reset("rst0");
        run(2);

        // Load 3A and scan.
        enable = 1'b1;
        offer(8'h3A);
        run(3 * FRAME);

        // Back-to-back values: second waits for the frame boundary.
        offer(8'h11);
        offer(8'h22);
        run(3 * FRAME);

        // Transfer exactly on the boundary edge with the buffer empty.
        budget = 0;
        while (!(frame_pos == FRAME - 1 && exp_q.size() == 0) && budget < 100) begin
            cycle();
            budget++;
        end
        check("boundary_reached", {7'b0, frame_pos == FRAME - 1}, 8'h01);
        value_in    = 8'h5C;
        value_valid = 1'b1;
        cycle();
        check("boundary_disp_kept", {1'b0, digit}, 8'h00);
        run(3 * FRAME);

        // Leading-zero blanking of the MSB digit.
        lz_blank = 1'b1;
        offer(8'h07);
        run(3 * FRAME);
        lz_blank = 1'b0;
        run(2 * FRAME);

        // Disable during the MSB phase; a value still reaches disp.
        budget = 0;
        while (!(frame_pos >= DIV && frame_pos < FRAME - 2) && budget < 100) begin
            cycle();
            budget++;
        end
        enable      = 1'b0;
        value_in    = 8'h9E;
        value_valid = 1'b1;
        run(4);
        enable = 1'b1;
        run(3 * FRAME);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if (!value_valid && $urandom_range(0, 3) == 0) begin
                value_in    = 8'($urandom);
                value_valid = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
            enable = ($urandom_range(0, 19) != 0);
            cycle();
        end

        // Mid-scan reset with a value pending: it must be discarded.
        enable = 1'b1;
        budget = 0;
        while (!(exp_q.size() == 1 && frame_pos >= DIV + 2 && frame_pos < FRAME - 1)
               && budget < 200) begin
            if (!value_valid) begin
                value_in    = 8'($urandom);
                value_valid = 1'b1;
            end
            cycle();
            budget++;
        end
        check("pend_full_before_reset", {7'b0, value_ready}, 8'h00);
        value_valid = 1'b0;
        async_reset("rst_mid");
        run(3 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
